// File: rtl/cmp_pkg.sv
// ============================================================================
// Module   : cmp_pkg
// Brief    : Shared FSM state encoding, streak width and one-hot helper for
//            the comparator event monitor.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package cmp_pkg;

  localparam int STREAK_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMING   = 2'd1,
    ALARM    = 2'd2,
    CLEARING = 2'd3
  } state_t;

  function automatic logic is_onehot3(input logic a, input logic b, input logic c);
    return (a & ~b & ~c) | (~a & b & ~c) | (~a & ~b & c);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cmp_event_monitor_sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Brief    : W-bit up-counter that saturates at all-ones; clear beats inc.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] c_MAX = '1;

  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != c_MAX)) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/cmp_event_monitor.sv
// ============================================================================
// Module   : cmp_event_monitor
// Brief    : Counts comparator outcomes and raises a debounced A>B alarm.
//            Optional macro CMP_ONEHOT_CHECK_EN adds a sticky err_onehot flag
//            and drops non-one-hot samples.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cmp_event_monitor
  import cmp_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int ALARM_N = 3,
  parameter int CLEAR_N = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             A_greater_B,
  input  logic             A_equal_B,
  input  logic             A_less_B,
  input  logic             clear_cnt,
  output logic [CNT_W-1:0] gt_count,
  output logic [CNT_W-1:0] eq_count,
  output logic [CNT_W-1:0] lt_count,
  output logic             alarm,
  output logic             alarm_rise,
  output logic [1:0]       state
`ifdef CMP_ONEHOT_CHECK_EN
  ,
  output logic             err_onehot
`endif
);

  localparam logic [STREAK_W-1:0] c_ALARM_LAST = STREAK_W'(ALARM_N);
  localparam logic [STREAK_W-1:0] c_CLEAR_LAST = STREAK_W'(CLEAR_N);

  logic                w_take;
  logic                w_gt;
  logic [STREAK_W-1:0] w_streak_inc;

  state_t              r_state;
  logic [STREAK_W-1:0] r_streak;
  logic                r_alarm;
  logic                r_alarm_rise;

`ifdef CMP_ONEHOT_CHECK_EN
  logic w_onehot;
  logic r_err_onehot;

  // A malformed sample is flagged but otherwise invisible to counters and FSM.
  assign w_onehot = is_onehot3(A_greater_B, A_equal_B, A_less_B);
  assign w_take   = in_valid & w_onehot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_onehot <= 1'b0;
    end else if (in_valid && !w_onehot) begin
      r_err_onehot <= 1'b1;
    end
  end

  assign err_onehot = r_err_onehot;
`else
  assign w_take = in_valid;
`endif

  assign w_gt         = A_greater_B;
  assign w_streak_inc = r_streak + STREAK_W'(1);

  sat_counter #(.W(CNT_W)) u_gt_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clear_cnt),
    .inc (w_take & A_greater_B),
    .q   (gt_count)
  );

  sat_counter #(.W(CNT_W)) u_eq_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clear_cnt),
    .inc (w_take & A_equal_B),
    .q   (eq_count)
  );

  sat_counter #(.W(CNT_W)) u_lt_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clear_cnt),
    .inc (w_take & A_less_B),
    .q   (lt_count)
  );

  // alarm tracks {ALARM, CLEARING}; alarm_rise fires only on the ARMING->ALARM entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_streak     <= '0;
      r_alarm      <= 1'b0;
      r_alarm_rise <= 1'b0;
    end else begin
      r_alarm_rise <= 1'b0;
      if (w_take) begin
        case (r_state)
          IDLE: begin
            if (w_gt) begin
              r_state  <= ARMING;
              r_streak <= STREAK_W'(1);
            end else begin
              r_streak <= '0;
            end
          end
          ARMING: begin
            if (w_gt) begin
              if (w_streak_inc == c_ALARM_LAST) begin
                r_state      <= ALARM;
                r_streak     <= '0;
                r_alarm      <= 1'b1;
                r_alarm_rise <= 1'b1;
              end else begin
                r_streak <= w_streak_inc;
              end
            end else begin
              r_state  <= IDLE;
              r_streak <= '0;
            end
          end
          ALARM: begin
            if (!w_gt) begin
              r_state  <= CLEARING;
              r_streak <= STREAK_W'(1);
            end
          end
          CLEARING: begin
            if (!w_gt) begin
              if (w_streak_inc == c_CLEAR_LAST) begin
                r_state  <= IDLE;
                r_streak <= '0;
                r_alarm  <= 1'b0;
              end else begin
                r_streak <= w_streak_inc;
              end
            end else begin
              r_state  <= ALARM;
              r_streak <= '0;
            end
          end
          default: begin
            r_state  <= IDLE;
            r_streak <= '0;
            r_alarm  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign alarm      = r_alarm;
  assign alarm_rise = r_alarm_rise;
  assign state      = r_state;

endmodule

`default_nettype wire
